load_store_multiple_sequencer: RTL
==================================

Name: load_store_multiple_sequencer

Overview:
Sequencer placed ahead of load_store_memory_stage.
- Accepts one LDM/STM/SWP command per handshake.
- Expands it into one single-word memory beat per cycle, driving the memory stage's start, address, rd_addr, store data, load/store mux controls, byte enables and multiple-enable fields.
- Computes the base write-back value and reports completion to the issue logic.

Parameters:
ADDR_W, 32, memory address / base register width
DATA_W, 32, register and memory data width
REG_ADDR_W, 4, register index width
TAG_W, 4, instruction tag width

Ports:
clk_in  in  1  clock, rising edge
reset_in  in  1  asynchronous active-high reset
cmd_valid_in  in  1  command present
cmd_ready_out  out  1  sequencer can accept a command (high only in IDLE)
cmd_tag_in  in  TAG_W  instruction tag
cmd_reg_list_in  in  16  register list, bit i = Ri
cmd_rn_addr_in  in  REG_ADDR_W  base register index
cmd_base_in  in  ADDR_W  base register value
cmd_mode_in  in  2  {P,U}: 00 DA, 01 IA, 10 DB, 11 IB
cmd_load_in  in  1  1 = LDM, 0 = STM
cmd_wb_in  in  1  base write-back requested
cmd_swp_in  in  1  SWP; cmd_reg_list_in[3:0] = Rd, [7:4] = Rm
rf_rd_addr_out  out  REG_ADDR_W  register-file read index for store data (combinational)
rf_rd_data_in  in  DATA_W  register-file read data, same cycle
abort_in  in  1  instruction squashed
ms_stall_in  in  1  memory stage cannot consume a beat this cycle
ms_start_out  out  1  beat valid (memory_stage_start)
ms_addr_out  out  ADDR_W  word address of beat
ms_rd_addr_out  out  REG_ADDR_W  destination/source register of beat
ms_store_data_out  out  DATA_W  store data
ms_load_mux_out  out  1  1 on load beats
ms_str_mux_out  out  1  1 on store beats
ms_w_en_out  out  4  4'hF on store beats, 0 on load beats
ms_swp_out  out  1  beat belongs to SWP
ms_multiple_en_out  out  1  high on every LDM/STM beat except the last
ms_tag_out  out  TAG_W  tag of current command
ms_rn_addr_out  out  REG_ADDR_W  base register index
ms_rn_data_out  out  ADDR_W  write-back base value
ms_rn_wb_out  out  1  high with the last beat when write-back is requested
done_out  out  1  one-cycle pulse after the last beat is consumed
busy_out  out  1  state != IDLE

Behaviour:
- States: IDLE, XFER, SWP_RD, SWP_WR, DONE.
- Reset: state IDLE, cmd_ready_out 1, all other outputs 0.
- Command handshake: accepted when cmd_valid_in && cmd_ready_out.
  - N = popcount(cmd_reg_list_in), 5-bit.
  - Start address:
    - IA: base
    - IB: base+4
    - DA: base-4N+4
    - DB: base-4N
  - Write-back value: base+4N if U=1, base-4N if U=0. Computed modulo 2^ADDR_W; wrap is allowed.
  - Next state: XFER if N>0; DONE if N=0 (no beats issued; ms_rn_data_out = base).
  - SWP: next state SWP_RD. Mode, wb and the rest of the list are ignored.
- Beat timing: a beat is registered in the cycle after acceptance. ms_start_out rises 1 cycle after the handshake.
- XFER:
  - Registers are issued in ascending index order. Address increments by 4 per consumed beat.
  - rf_rd_addr_out always shows the lowest pending register. rf_rd_data_in is captured into ms_store_data_out when that beat is registered.
  - Beat consumed when ms_start_out && !ms_stall_in.
  - While stalled, all ms_* outputs are held unchanged.
  - After the last beat is consumed: DONE, ms_start_out 0.
- SWP_RD: load beat at base, rd = Rd, ms_swp_out 1. On consumption go to SWP_WR.
- SWP_WR: store beat at base, data = R[Rm] captured when the beat is registered, ms_swp_out 1. On consumption go to DONE.
- DONE: done_out 1 for one cycle, then IDLE.
- abort_in: highest priority except reset. Next cycle: IDLE, ms_start_out 0, no done_out, no write-back. In IDLE, abort_in is ignored; a command presented with abort_in in the same cycle is not accepted.
- cmd_valid_in is ignored outside IDLE. The next command can be accepted in the cycle after the done_out pulse.
- Asynchronous reset mid-command: immediate return to reset values; the partial command is dropped.

Test Plan:
- STM IA, base 0x100, list 0x000E, wb=1, no stall -> beats at cycles 1..3: addr 0x100/0x104/0x108, rd 1/2/3, w_en F; multiple_en 1,1,0; rn_wb 1 with rn_data 0x10C on the last beat; done_out at cycle 4.
- LDM DB, base 0x200, list 0x8001 -> addr 0x1F8 (rd 0), 0x1FC (rd 15); load_mux 1, w_en 0; rn_data 0x1F8.
- LDM IA, 3 registers, ms_stall_in high for 2 cycles on beat 2 -> beat 2 outputs held 3 cycles; total 5 beat cycles; addresses unchanged.
- SWP Rd=4, Rm=5, base 0x40, R5=0xDEADBEEF -> load beat at 0x40 rd 4, then store beat at 0x40 with data 0xDEADBEEF, w_en F; done_out after both beats.
- abort_in during beat 2 of a 4-register STM -> ms_start_out 0 next cycle, no done_out, cmd_ready_out 1.
- Empty list with DA, base 0x0 -> no ms_start_out; done_out pulses 1 cycle after acceptance. Separately, IB base 0xFFFFFFFC, list 0x0001 -> address wraps to 0x0.

Source files
------------

// File: rtl/load_store_multiple_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : load_store_multiple_sequencer
// Purpose  : Front end for the load/store memory stage. Accepts one
//            LDM / STM / SWP command per handshake and expands it into a
//            sequence of single-word memory beats, one per cycle. It also
//            computes the base write-back value and signals completion to
//            the issue logic.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in, reset_in      clock (rising edge), asynchronous active-high reset
//   cmd_*                 command handshake: tag, register list, base index and
//                         value, {P,U} mode, load/wb/swp flags
//   rf_rd_addr_out/_in    register-file read port used to fetch store data
//   abort_in              squash the command in flight
//   ms_stall_in           memory stage cannot take the presented beat
//   ms_*_out              registered beat presented to the memory stage
//   done_out              one-cycle completion pulse
//   busy_out              a command is in flight
// ============================================================================
module load_store_multiple_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int TAG_W      = 4
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    // command interface
    input  logic                  cmd_valid_in,
    output logic                  cmd_ready_out,
    input  logic [TAG_W-1:0]      cmd_tag_in,
    input  logic [15:0]           cmd_reg_list_in,
    input  logic [REG_ADDR_W-1:0] cmd_rn_addr_in,
    input  logic [ADDR_W-1:0]     cmd_base_in,
    input  logic [1:0]            cmd_mode_in,
    input  logic                  cmd_load_in,
    input  logic                  cmd_wb_in,
    input  logic                  cmd_swp_in,
    // register-file read port
    output logic [REG_ADDR_W-1:0] rf_rd_addr_out,
    input  logic [DATA_W-1:0]     rf_rd_data_in,
    // control
    input  logic                  abort_in,
    input  logic                  ms_stall_in,
    // memory-stage beat
    output logic                  ms_start_out,
    output logic [ADDR_W-1:0]     ms_addr_out,
    output logic [REG_ADDR_W-1:0] ms_rd_addr_out,
    output logic [DATA_W-1:0]     ms_store_data_out,
    output logic                  ms_load_mux_out,
    output logic                  ms_str_mux_out,
    output logic [3:0]            ms_w_en_out,
    output logic                  ms_swp_out,
    output logic                  ms_multiple_en_out,
    output logic [TAG_W-1:0]      ms_tag_out,
    output logic [REG_ADDR_W-1:0] ms_rn_addr_out,
    output logic [ADDR_W-1:0]     ms_rn_data_out,
    output logic                  ms_rn_wb_out,
    // status
    output logic                  done_out,
    output logic                  busy_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_XFER   = 3'd1;
    localparam logic [2:0] c_SWP_RD = 3'd2;
    localparam logic [2:0] c_SWP_WR = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    localparam logic [ADDR_W-1:0] c_WORD_BYTES = ADDR_W'(4);
    localparam logic [3:0]        c_W_EN_ALL   = 4'hF;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic logic [4:0] f_popcount(input logic [15:0] list);
        f_popcount = 5'd0;
        for (int i = 0; i < 16; i++) begin
            f_popcount = f_popcount + 5'(list[i]);
        end
    endfunction

    // Index of the lowest set bit; scanning downwards lets the lowest hit win.
    function automatic logic [REG_ADDR_W-1:0] f_lowest(input logic [15:0] list);
        f_lowest = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list[i]) begin
                f_lowest = REG_ADDR_W'(i);
            end
        end
    endfunction

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [15:0]           r_pending;   // registers not yet presented as beats
    logic [REG_ADDR_W-1:0] r_rm;        // SWP store source register
    logic                  r_wb;        // write-back requested for this command

    logic                  r_ms_start;
    logic [ADDR_W-1:0]     r_ms_addr;
    logic [REG_ADDR_W-1:0] r_ms_rd_addr;
    logic [DATA_W-1:0]     r_ms_store_data;
    logic                  r_ms_load_mux;
    logic                  r_ms_str_mux;
    logic [3:0]            r_ms_w_en;
    logic                  r_ms_swp;
    logic                  r_ms_multiple_en;
    logic [TAG_W-1:0]      r_ms_tag;
    logic [REG_ADDR_W-1:0] r_ms_rn_addr;
    logic [ADDR_W-1:0]     r_ms_rn_data;
    logic                  r_ms_rn_wb;
    logic                  r_done;

    // ------------------------------------------------------------------------
    // Combinational decode of the incoming command
    // ------------------------------------------------------------------------
    logic                  w_accept;
    logic [4:0]            w_n;
    logic [ADDR_W-1:0]     w_four_n;
    logic [ADDR_W-1:0]     w_start_addr;
    logic [ADDR_W-1:0]     w_wb_value;
    logic [15:0]           w_rest;          // command list minus its first register
    logic [15:0]           w_pending_rest;  // pending list minus its first register
    logic [REG_ADDR_W-1:0] w_rf_rd_addr;

    assign w_accept       = cmd_valid_in && (r_state == c_IDLE) && !abort_in;
    assign w_n            = f_popcount(cmd_reg_list_in);
    assign w_four_n       = ADDR_W'({w_n, 2'b00});
    assign w_rest         = cmd_reg_list_in & (cmd_reg_list_in - 16'd1);
    assign w_pending_rest = r_pending & (r_pending - 16'd1);

    // U selects the direction of the base update; arithmetic wraps freely.
    assign w_wb_value = cmd_mode_in[0] ? (cmd_base_in + w_four_n)
                                       : (cmd_base_in - w_four_n);

    // Beats always run upward in address, so decrementing modes start at the
    // bottom of the block that is being transferred.
    always_comb begin
        w_start_addr = cmd_base_in;
        case (cmd_mode_in)
            2'b00:   w_start_addr = cmd_base_in - w_four_n + c_WORD_BYTES; // DA
            2'b01:   w_start_addr = cmd_base_in;                           // IA
            2'b10:   w_start_addr = cmd_base_in - w_four_n;                // DB
            default: w_start_addr = cmd_base_in + c_WORD_BYTES;            // IB
        endcase
    end

    // The read index always points at the register whose data will be
    // captured at the next beat-registering edge.
    always_comb begin
        w_rf_rd_addr = '0;
        case (r_state)
            c_IDLE:   w_rf_rd_addr = f_lowest(cmd_reg_list_in);
            c_XFER:   w_rf_rd_addr = f_lowest(r_pending);
            c_SWP_RD: w_rf_rd_addr = r_rm;
            default:  w_rf_rd_addr = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state          <= c_IDLE;
            r_pending        <= '0;
            r_rm             <= '0;
            r_wb             <= 1'b0;
            r_ms_start       <= 1'b0;
            r_ms_addr        <= '0;
            r_ms_rd_addr     <= '0;
            r_ms_store_data  <= '0;
            r_ms_load_mux    <= 1'b0;
            r_ms_str_mux     <= 1'b0;
            r_ms_w_en        <= 4'h0;
            r_ms_swp         <= 1'b0;
            r_ms_multiple_en <= 1'b0;
            r_ms_tag         <= '0;
            r_ms_rn_addr     <= '0;
            r_ms_rn_data     <= '0;
            r_ms_rn_wb       <= 1'b0;
            r_done           <= 1'b0;
        end else if (abort_in && (r_state != c_IDLE)) begin
            // Squash: drop everything in flight, no completion, no write-back.
            r_state          <= c_IDLE;
            r_pending        <= '0;
            r_ms_start       <= 1'b0;
            r_ms_load_mux    <= 1'b0;
            r_ms_str_mux     <= 1'b0;
            r_ms_w_en        <= 4'h0;
            r_ms_swp         <= 1'b0;
            r_ms_multiple_en <= 1'b0;
            r_ms_rn_wb       <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_ms_tag        <= cmd_tag_in;
                        r_ms_rn_addr    <= cmd_rn_addr_in;
                        r_ms_store_data <= rf_rd_data_in;
                        if (cmd_swp_in) begin
                            // Load half of the swap; list carries Rd and Rm.
                            r_state          <= c_SWP_RD;
                            r_rm             <= REG_ADDR_W'(cmd_reg_list_in[7:4]);
                            r_wb             <= 1'b0;
                            r_ms_start       <= 1'b1;
                            r_ms_addr        <= cmd_base_in;
                            r_ms_rd_addr     <= REG_ADDR_W'(cmd_reg_list_in[3:0]);
                            r_ms_load_mux    <= 1'b1;
                            r_ms_str_mux     <= 1'b0;
                            r_ms_w_en        <= 4'h0;
                            r_ms_swp         <= 1'b1;
                            r_ms_multiple_en <= 1'b0;
                            r_ms_rn_data     <= cmd_base_in;
                            r_ms_rn_wb       <= 1'b0;
                        end else if (w_n == 5'd0) begin
                            // Empty list: nothing to transfer, base unchanged.
                            r_state      <= c_DONE;
                            r_wb         <= 1'b0;
                            r_ms_rn_data <= cmd_base_in;
                            r_done       <= 1'b1;
                        end else begin
                            r_state          <= c_XFER;
                            r_pending        <= w_rest;
                            r_wb             <= cmd_wb_in;
                            r_ms_start       <= 1'b1;
                            r_ms_addr        <= w_start_addr;
                            r_ms_rd_addr     <= f_lowest(cmd_reg_list_in);
                            r_ms_load_mux    <= cmd_load_in;
                            r_ms_str_mux     <= !cmd_load_in;
                            r_ms_w_en        <= cmd_load_in ? 4'h0 : c_W_EN_ALL;
                            r_ms_swp         <= 1'b0;
                            r_ms_multiple_en <= (w_rest != 16'd0);
                            r_ms_rn_data     <= w_wb_value;
                            r_ms_rn_wb       <= cmd_wb_in && (w_rest == 16'd0);
                        end
                    end
                end

                c_XFER: begin
                    // A beat is always on offer here; a stall holds it as is.
                    if (!ms_stall_in) begin
                        if (r_pending != 16'd0) begin
                            r_pending        <= w_pending_rest;
                            r_ms_addr        <= r_ms_addr + c_WORD_BYTES;
                            r_ms_rd_addr     <= f_lowest(r_pending);
                            r_ms_store_data  <= rf_rd_data_in;
                            r_ms_multiple_en <= (w_pending_rest != 16'd0);
                            r_ms_rn_wb       <= r_wb && (w_pending_rest == 16'd0);
                        end else begin
                            r_state          <= c_DONE;
                            r_done           <= 1'b1;
                            r_ms_start       <= 1'b0;
                            r_ms_load_mux    <= 1'b0;
                            r_ms_str_mux     <= 1'b0;
                            r_ms_w_en        <= 4'h0;
                            r_ms_multiple_en <= 1'b0;
                            r_ms_rn_wb       <= 1'b0;
                        end
                    end
                end

                c_SWP_RD: begin
                    if (!ms_stall_in) begin
                        // Store half: same address, data from Rm.
                        r_state         <= c_SWP_WR;
                        r_ms_rd_addr    <= r_rm;
                        r_ms_store_data <= rf_rd_data_in;
                        r_ms_load_mux   <= 1'b0;
                        r_ms_str_mux    <= 1'b1;
                        r_ms_w_en       <= c_W_EN_ALL;
                    end
                end

                c_SWP_WR: begin
                    if (!ms_stall_in) begin
                        r_state       <= c_DONE;
                        r_done        <= 1'b1;
                        r_ms_start    <= 1'b0;
                        r_ms_str_mux  <= 1'b0;
                        r_ms_w_en     <= 4'h0;
                        r_ms_swp      <= 1'b0;
                    end
                end

                c_DONE: begin
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cmd_ready_out      = (r_state == c_IDLE);
    assign busy_out           = (r_state != c_IDLE);
    assign rf_rd_addr_out     = w_rf_rd_addr;
    assign ms_start_out       = r_ms_start;
    assign ms_addr_out        = r_ms_addr;
    assign ms_rd_addr_out     = r_ms_rd_addr;
    assign ms_store_data_out  = r_ms_store_data;
    assign ms_load_mux_out    = r_ms_load_mux;
    assign ms_str_mux_out     = r_ms_str_mux;
    assign ms_w_en_out        = r_ms_w_en;
    assign ms_swp_out         = r_ms_swp;
    assign ms_multiple_en_out = r_ms_multiple_en;
    assign ms_tag_out         = r_ms_tag;
    assign ms_rn_addr_out     = r_ms_rn_addr;
    assign ms_rn_data_out     = r_ms_rn_data;
    assign ms_rn_wb_out       = r_ms_rn_wb;
    assign done_out           = r_done;

endmodule
`default_nettype wire
